led_blink_multi: RTL and testbench

LED_BLINK_MULTI -- requirements
Module: led_blink_multi

---
 rtl/led_blink_pkg.sv | 31 +++
 rtl/led_blink_multi_if.sv | 12 +
 rtl/led_blink_ch.sv | 52 +++++
 rtl/led_blink_multi.sv | 52 +++++
 tb/tb_led_blink_multi.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
package led_blink_pkg;

  // Per-channel speed code: step = 2^code.
  typedef logic [1:0] speed_t;

  // Widest step is 8, so four bits hold every step value.
  localparam int unsigned StepW = 4;

  // Supported parameter ranges.
  localparam int unsigned NChMin   = 1;
  localparam int unsigned NChMax   = 16;
  localparam int unsigned CntWMin  = 4;
  localparam int unsigned CntWMax  = 32;
  localparam int unsigned SyncMin  = 2;
  localparam int unsigned SyncMax  = 4;

  // Increment step selected by a speed code (1, 2, 4, 8).
  function automatic logic [StepW-1:0] step_of(speed_t code);
    return 4'b0001 << code;
  endfunction

  // True when a parameter set lies inside the supported ranges.
  function automatic bit params_ok(int unsigned n_ch, int unsigned cnt_w,
                                   int unsigned sync_stages);
    return (n_ch >= NChMin) && (n_ch <= NChMax) &&
           (cnt_w >= CntWMin) && (cnt_w <= CntWMax) &&
           (sync_stages >= SyncMin) && (sync_stages <= SyncMax);
  endfunction

endpackage

// File: rtl/led_blink_multi_if.sv
// Bundle of the speed/enable inputs and led/wrap outputs of the blinker.
interface led_blink_multi_if #(
  parameter int unsigned N_CH = 2
);
  logic [2*N_CH-1:0] sw;
  logic [N_CH-1:0]   en;
  logic [N_CH-1:0]   led;
  logic [N_CH-1:0]   wrap;

  modport master (output sw, output en, input led, input wrap);
  modport slave  (input sw, input en, output led, output wrap);
endinterface

// File: rtl/led_blink_ch.sv
// One blink channel: free-running counter with carry strobe and registered MSB output.
module led_blink_ch
  import led_blink_pkg::*;
#(
  parameter int unsigned CNT_W = 26
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en_s,
  input  speed_t code,
  output logic   led,
  output logic   wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W:0]   sum;
  logic [StepW-1:0] step;

  // Next counter value, carry and led; a disabled channel is held cleared.
  always_comb begin
    step   = step_of(code);
    sum    = {1'b0, cnt_q} + {{(CNT_W - StepW + 1){1'b0}}, step};
    cnt_d  = '0;
    wrap_d = 1'b0;
    led_d  = 1'b0;
    if (en_s) begin
      cnt_d  = sum[CNT_W-1:0];
      wrap_d = sum[CNT_W];
      // led lags the counter MSB by one cycle.
      led_d  = cnt_q[CNT_W-1];
    end
  end

  // Channel state; reset discards phase without producing a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      led_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      led_q  <= led_d;
    end
  end

  assign led  = led_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: shared input synchronisers feeding N_CH channels.
module led_blink_multi
  import led_blink_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  led_blink_multi_if.slave bus
);

  // Stage 0 samples the asynchronous pins; the last stage is the usable copy.
  logic [SYNC_STAGES-1:0][2*N_CH-1:0] sw_sync_q;
  logic [SYNC_STAGES-1:0][N_CH-1:0]   en_sync_q;
  logic [2*N_CH-1:0]                  sw_s;
  logic [N_CH-1:0]                    en_s;
  logic [N_CH-1:0]                    led_w;
  logic [N_CH-1:0]                    wrap_w;

  // Synchroniser chains for the speed codes and enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync_q <= '0;
      en_sync_q <= '0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], bus.sw};
      en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], bus.en};
    end
  end

  assign sw_s = sw_sync_q[SYNC_STAGES-1];
  assign en_s = en_sync_q[SYNC_STAGES-1];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    led_blink_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en_s (en_s[c]),
      .code (sw_s[2*c +: 2]),
      .led  (led_w[c]),
      .wrap (wrap_w[c])
    );
  end

  assign bus.led  = led_w;
  assign bus.wrap = wrap_w;

endmodule

// File: tb/tb_led_blink_multi.sv
// Self-checking bench for led_blink_multi (N_CH=2, CNT_W=4, SYNC_STAGES=2).
module tb_led_blink_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_blink_multi_if #(.N_CH(2)) bus ();

  led_blink_multi #(
    .N_CH        (2),
    .CNT_W       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: counters as integers modulo 16, two-deep input delay line.
  int         cnt_m [2];
  bit         led_m [2];
  bit         wrap_m[2];
  logic [3:0] sw_p0, sw_p1;
  logic [1:0] en_p0, en_p1;
  string      phase = "reset";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      cnt_m[c]  = 0;
      led_m[c]  = 1'b0;
      wrap_m[c] = 1'b0;
    end
    sw_p0 = '0;
    sw_p1 = '0;
    en_p0 = '0;
    en_p1 = '0;
  endtask

  task automatic check_all();
    chk({phase, ".led"},  32'(bus.led),  {30'd0, led_m[1], led_m[0]});
    chk({phase, ".wrap"}, 32'(bus.wrap), {30'd0, wrap_m[1], wrap_m[0]});
    chk({phase, ".cnt0"}, 32'(dut.g_ch[0].u_ch.cnt_q), cnt_m[0]);
    chk({phase, ".cnt1"}, 32'(dut.g_ch[1].u_ch.cnt_q), cnt_m[1]);
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (en_p1[c]) begin
          int step;
          int sum;
          step      = 1 << int'(sw_p1[2*c +: 2]);
          sum       = cnt_m[c] + step;
          led_m[c]  = (cnt_m[c] >= 8);
          wrap_m[c] = (sum >= 16);
          cnt_m[c]  = sum % 16;
        end else begin
          cnt_m[c]  = 0;
          led_m[c]  = 1'b0;
          wrap_m[c] = 1'b0;
        end
      end
      en_p1 = en_p0;
      en_p0 = bus.en;
      sw_p1 = sw_p0;
      sw_p0 = bus.sw;
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset entry: outputs and counters must clear without a clock.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
  endtask

  initial begin
    int wraps0, wraps1, highs, toggles, last, prev, n;
    bit found;

    bus.sw = '0;
    bus.en = '0;
    model_clear();
    #1;
    check_all();
    repeat (3) tick();
    rst = 1'b0;

    // Outputs stay low while the enable crosses the synchroniser.
    phase  = "req022";
    bus.en = 2'b11;
    repeat (2) tick();
    chk("req022.led_quiet", 32'(bus.led | bus.wrap), 32'd0);
    repeat (3) tick();

    // Reset pulse mid-count.
    phase = "req028";
    async_reset();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("req028.cnt0_release", 32'(dut.g_ch[0].u_ch.cnt_q), 32'd0);
    chk("req028.cnt1_release", 32'(dut.g_ch[1].u_ch.cnt_q), 32'd0);

    // Step 1 on channel 0: wrap every 16, led 8 high / 8 low.
    phase  = "req029";
    bus.en = 2'b00;
    repeat (4) tick();
    bus.sw = 4'b0000;
    bus.en = 2'b01;
    repeat (2) tick();
    wraps0 = 0;
    highs  = 0;
    last   = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus.led[0]) highs++;
      if (bus.wrap[0]) begin
        wraps0++;
        if (last >= 0) chk("req029.period", i - last, 16);
        last = i;
      end
    end
    chk("req029.wraps", wraps0, 4);
    chk("req029.led_high", highs, 32);

    // Step 8: wrap every 2 cycles, led toggling every cycle.
    phase  = "req030";
    bus.sw = 4'b0011;
    repeat (2) tick();
    wraps0  = 0;
    toggles = 0;
    prev    = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.wrap[0]) wraps0++;
      if (prev >= 0 && int'(bus.led[0]) != prev) toggles++;
      prev = int'(bus.led[0]);
    end
    chk("req030.wraps", wraps0, 8);
    chk("req030.toggles", toggles, 15);

    // Phase-continuous speed change 1 -> 4 from counter 6.
    phase  = "req031";
    bus.sw = 4'b0000;
    repeat (2) tick();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (cnt_m[0] == 4) found = 1'b1;
    end
    chk("req031.reach4", 32'(found), 32'd1);
    bus.sw = 4'b0010;
    tick();
    tick();
    chk("req031.cnt6", 32'(dut.g_ch[0].u_ch.cnt_q), 32'd6);
    tick();
    chk("req031.cnt10", 32'(dut.g_ch[0].u_ch.cnt_q), 32'd10);
    tick();
    chk("req031.cnt14", 32'(dut.g_ch[0].u_ch.cnt_q), 32'd14);
    chk("req031.nowrap", 32'(bus.wrap[0]), 32'd0);
    tick();
    chk("req031.cnt2", 32'(dut.g_ch[0].u_ch.cnt_q), 32'd2);
    chk("req031.wrap", 32'(bus.wrap[0]), 32'd1);

    // Drop channel 1 at counter 12, then re-enable.
    phase  = "req032";
    bus.sw = 4'b0000;
    bus.en = 2'b11;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (en_p1[1] && cnt_m[1] == 10) found = 1'b1;
    end
    chk("req032.reach10", 32'(found), 32'd1);
    bus.en = 2'b01;
    tick();
    tick();
    chk("req032.cnt12", 32'(dut.g_ch[1].u_ch.cnt_q), 32'd12);
    chk("req032.led_before", 32'(bus.led[1]), 32'd1);
    tick();
    chk("req032.led_off", 32'(bus.led[1]), 32'd0);
    chk("req032.cnt_cleared", 32'(dut.g_ch[1].u_ch.cnt_q), 32'd0);
    repeat (3) tick();
    bus.en = 2'b11;
    found  = 1'b0;
    n      = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      n++;
      if (bus.wrap[1]) found = 1'b1;
    end
    chk("req032.wrap_seen", 32'(found), 32'd1);
    chk("req032.first_wrap", n, 18);

    // Both channels step 2, enabled together: coincident wraps every 8.
    phase  = "req033";
    bus.en = 2'b00;
    repeat (4) tick();
    bus.sw = 4'b0101;
    bus.en = 2'b11;
    wraps0 = 0;
    wraps1 = 0;
    n      = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (bus.wrap[0]) wraps0++;
      if (bus.wrap[1]) wraps1++;
      if (bus.wrap[0] && bus.wrap[1]) n++;
    end
    chk("req033.wraps0", wraps0, 3);
    chk("req033.wraps1", wraps1, 3);
    chk("req033.coincide", n, 3);

    // Random speeds, enables and occasional reset pulses against the model.
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.sw = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.en = 2'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
